// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode constants and controller state encoding for alu_seq_ctrl.
package alu_seq_ctrl_pkg;

  localparam logic [4:0] kADD  = 5'h00;
  localparam logic [4:0] kSUB  = 5'h01;
  localparam logic [4:0] kAND  = 5'h02;
  localparam logic [4:0] kXOR  = 5'h03;
  localparam logic [4:0] kSLL  = 5'h04;
  localparam logic [4:0] kSRL  = 5'h05;
  localparam logic [4:0] kMOV  = 5'h06;
  localparam logic [4:0] kCMP  = 5'h07;
  localparam logic [4:0] kBE   = 5'h08;
  localparam logic [4:0] kBL   = 5'h09;
  localparam logic [4:0] kBG   = 5'h0A;
  localparam logic [4:0] kBA   = 5'h0B;
  localparam logic [4:0] kLD   = 5'h0C;
  localparam logic [4:0] kST   = 5'h0D;
  localparam logic [4:0] kHALT = 5'h1F;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM_WAIT,
    WB,
    HALTED
  } ctrl_state_t;

endpackage

// File: rtl/alu_seq_ctrl_branch_resolve.sv
// Branch condition evaluation from the latched CMP flags.
module branch_resolve
  import alu_seq_ctrl_pkg::*;
(
  input  logic [4:0] op,
  input  logic       flag_lt,
  input  logic       flag_z,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      kBE:     taken = flag_z;
      kBL:     taken = flag_lt;
      kBG:     taken = !flag_z && !flag_lt;
      kBA:     taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/exec/mem/writeback sequencer for the core datapath.
// Optional ALU_SEQ_PERF_EN adds saturating cycle and retire counters.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            done,
  output logic            fault,
  output logic [PC_W-1:0] pc,
  input  logic [8:0]      instr,
  output logic [4:0]      alu_op,
  input  logic [7:0]      alu_rslt,
  input  logic            alu_lt,
  input  logic            alu_z,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            flag_lt,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0]     cyc_cnt,
  output logic [15:0]     ret_cnt,
`endif
  output logic            flag_z
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [PC_W-1:0]  PcOne    = PC_W'(1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  ctrl_state_t     state_q;
  logic [PC_W-1:0] pc_q;
  logic            flag_lt_q, flag_z_q, fault_q, mem_we_q, rf_wsel_q;
  logic [WaitW-1:0] wait_q;
  logic [4:0]      op;
  logic            taken;
  logic            unused_instr;

  assign op           = instr[8:4];
  assign unused_instr = ^instr[3:0];

  branch_resolve u_branch_resolve (
    .op      (op),
    .flag_lt (flag_lt_q),
    .flag_z  (flag_z_q),
    .taken   (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      flag_lt_q <= 1'b0;
      flag_z_q  <= 1'b0;
      fault_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      rf_wsel_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= FETCH;
        FETCH: state_q <= EXEC;
        EXEC: begin
          case (op)
            kADD, kSUB, kAND, kXOR, kSLL, kSRL, kMOV: begin
              rf_wsel_q <= 1'b0;
              state_q   <= WB;
            end
            kCMP: begin
              flag_lt_q <= alu_lt;
              flag_z_q  <= alu_z;
              pc_q      <= pc_q + PcOne;
              state_q   <= FETCH;
            end
            kBE, kBL, kBG, kBA: begin
              // Branch target arrives through the ALU as in_b.
              pc_q    <= taken ? alu_rslt[PC_W-1:0] : pc_q + PcOne;
              state_q <= FETCH;
            end
            kLD, kST: begin
              mem_we_q <= (op == kST);
              wait_q   <= '0;
              state_q  <= MEM_WAIT;
            end
            kHALT: state_q <= HALTED;
            default: begin
              pc_q    <= pc_q + PcOne;
              state_q <= FETCH;
            end
          endcase
        end
        MEM_WAIT: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (mem_ack) begin
            if (mem_we_q) begin
              pc_q    <= pc_q + PcOne;
              state_q <= FETCH;
            end else begin
              rf_wsel_q <= 1'b1;
              state_q   <= WB;
            end
          end else if (wait_q == WaitLast) begin
            fault_q <= 1'b1;
            state_q <= HALTED;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        WB: begin
          pc_q    <= pc_q + PcOne;
          state_q <= FETCH;
        end
        HALTED: begin
          if (start) begin
            pc_q      <= '0;
            flag_lt_q <= 1'b0;
            flag_z_q  <= 1'b0;
            fault_q   <= 1'b0;
            state_q   <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request and strobes decode straight from state so reset drops them immediately.
  assign done    = (state_q == HALTED);
  assign rf_we   = (state_q == WB);
  assign mem_req = (state_q == MEM_WAIT);
  assign mem_we  = mem_we_q & mem_req;
  assign alu_op  = (state_q == EXEC) ? op : kMOV;
  assign pc      = pc_q;
  assign fault   = fault_q;
  assign flag_lt = flag_lt_q;
  assign flag_z  = flag_z_q;
  assign rf_wsel = rf_wsel_q;

`ifdef ALU_SEQ_PERF_EN
  logic cnt_clr, cyc_inc, ret_inc;

  assign cnt_clr = start && (state_q == IDLE || state_q == HALTED);
  assign cyc_inc = (state_q != IDLE) && (state_q != HALTED);
  assign ret_inc = (state_q == WB) ||
                   (state_q == EXEC && (op == kCMP || op == kBE || op == kBL ||
                                        op == kBG || op == kBA)) ||
                   (state_q == MEM_WAIT && mem_ack && mem_we_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (cyc_inc && cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
      if (ret_inc && ret_cnt != 16'hFFFF) ret_cnt <= ret_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small instruction memory model.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done, fault;
  logic [7:0] pc;
  logic [8:0] instr;
  logic [4:0] alu_op;
  logic [7:0] alu_rslt = 8'h00;
  logic       alu_lt = 1'b0;
  logic       alu_z = 1'b0;
  logic       rf_we, rf_wsel, mem_req, mem_we;
  logic       mem_ack = 1'b0;
  logic       flag_lt, flag_z;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] cyc_cnt, ret_cnt;
`endif

  logic [8:0] prog [256];
  int n_tests = 0;
  int n_fail  = 0;
  int hi;

  assign instr = prog[pc];

  alu_seq_ctrl #(.PC_W(8), .MEM_TIMEOUT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .fault    (fault),
    .pc       (pc),
    .instr    (instr),
    .alu_op   (alu_op),
    .alu_rslt (alu_rslt),
    .alu_lt   (alu_lt),
    .alu_z    (alu_z),
    .rf_we    (rf_we),
    .rf_wsel  (rf_wsel),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .flag_lt  (flag_lt),
`ifdef ALU_SEQ_PERF_EN
    .cyc_cnt  (cyc_cnt),
    .ret_cnt  (ret_cnt),
`endif
    .flag_z   (flag_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ins(input logic [4:0] op);
    return {op, 4'h0};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = ins(kHALT);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      step();
    end
    check(tag, done, 1);
  endtask

  // Counts MEM_WAIT cycles; raises ack on the ack_at-th one (0 = never).
  task automatic mem_phase(input int ack_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      cnt++;
      mem_ack = (cnt == ack_at);
      step();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_prog();
    step();
    step();
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", pc, 0);
    check("rst_alu_op", alu_op, 32'h06);
    check("rst_mem_req", mem_req, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_flags", {flag_lt, flag_z}, 0);
    reset = 1'b0;
    step();

    // ADD, HALT
    prog[0] = ins(kADD);
    prog[1] = ins(kHALT);
    start_pulse();
    check("add_fetch_pc", pc, 0);
    step();
    check("add_exec_op", alu_op, 32'h00);
    check("add_exec_we", rf_we, 0);
    step();
    check("add_wb_we", rf_we, 1);
    check("add_wb_sel", rf_wsel, 0);
    step();
    check("add_fetch2_we", rf_we, 0);
    check("add_pc", pc, 1);
    step();
    check("halt_exec_op", alu_op, 32'h1F);
    check("halt_exec_done", done, 0);
    step();
    check("add_done", done, 1);
    check("add_halt_pc", pc, 1);
    step();
    check("halt_hold_pc", pc, 1);

    // CMP z=1 then BE taken
    clear_prog();
    prog[0] = ins(kCMP);
    prog[1] = ins(kBE);
    alu_z = 1'b1; alu_lt = 1'b0; alu_rslt = 8'h20;
    start_pulse();
    check("restart_pc", pc, 0);
    step(); step();
    check("cmp_flag_z", flag_z, 1);
    check("cmp_flag_lt", flag_lt, 0);
    check("cmp_pc", pc, 1);
    step(); step();
    check("be_taken_pc", pc, 32'h20);
    run_to_halt("be_taken_halt");

    // CMP z=0 then BE not taken
    alu_z = 1'b0;
    start_pulse();
    step(); step();
    check("cmp2_flag_z", flag_z, 0);
    step(); step();
    check("be_nt_pc", pc, 2);
    run_to_halt("be_nt_halt");

    // CMP lt=0 z=0, BG taken, BL not taken; live ALU flags disagree
    clear_prog();
    prog[0]     = ins(kCMP);
    prog[1]     = ins(kBG);
    prog[8'h30] = ins(kBL);
    alu_lt = 1'b0; alu_z = 1'b0;
    start_pulse();
    step(); step();
    check("cmp3_flags", {flag_lt, flag_z}, 0);
    alu_lt = 1'b1; alu_z = 1'b1; alu_rslt = 8'h30;
    step(); step();
    check("bg_taken_pc", pc, 32'h30);
    alu_rslt = 8'h40;
    step(); step();
    check("bl_nt_pc", pc, 32'h31);
    run_to_halt("bl_halt");
    alu_lt = 1'b0; alu_z = 1'b0;

    // LD with ack on the 4th wait cycle; early acks must be ignored
    clear_prog();
    prog[0] = ins(kLD);
    start_pulse();
    mem_ack = 1'b1;
    step();
    check("ld_exec_op", alu_op, 32'h0C);
    check("ld_exec_req", mem_req, 0);
    step();
    mem_ack = 1'b0;
    check("ld_req", mem_req, 1);
    check("ld_we", mem_we, 0);
    mem_phase(4, hi);
    check("ld_req_cycles", hi, 4);
    check("ld_wb_we", rf_we, 1);
    check("ld_wb_sel", rf_wsel, 1);
    check("ld_wb_req", mem_req, 0);
    step();
    check("ld_pc", pc, 1);
    check("ld_we_off", rf_we, 0);
    run_to_halt("ld_halt");
    check("ld_fault", fault, 0);

    // NOP then ST with no ack: timeout fault
    clear_prog();
    prog[0] = ins(5'h0E);
    prog[1] = ins(kST);
    start_pulse();
    step(); step();
    check("nop_pc", pc, 1);
    step(); step();
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    mem_phase(0, hi);
    check("st_timeout_cycles", hi, 15);
    check("st_fault", fault, 1);
    check("st_done", done, 1);
    check("st_fault_pc", pc, 1);
    start_pulse();
    check("clr_fault", fault, 0);
    check("clr_pc", pc, 0);
    check("clr_done", done, 0);

    // Ack on the last allowed cycle counts as success
    step(); step(); step(); step();
    mem_phase(15, hi);
    check("st_late_cycles", hi, 15);
    check("st_late_pc", pc, 2);
    check("st_late_fault", fault, 0);
    check("st_late_done", done, 0);
    run_to_halt("st_late_halt");

    // PC wrap 0xFF -> 0x00, then reset during MEM_WAIT
    clear_prog();
    prog[0]     = ins(kBA);
    prog[8'hFF] = ins(kADD);
    prog[8'h50] = ins(kLD);
    alu_rslt = 8'hFF;
    start_pulse();
    step(); step();
    check("ba_pc_ff", pc, 32'hFF);
    step(); step(); step();
    check("wrap_pc", pc, 0);
    alu_rslt = 8'h50;
    step(); step();
    check("ba_pc_50", pc, 32'h50);
    step(); step();
    check("rst_ld_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("async_req_drop", mem_req, 0);
    check("async_pc", pc, 0);
    check("async_done", done, 0);
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    check("idle_hold_pc", pc, 0);
    check("idle_hold_op", alu_op, 32'h06);
    check("idle_hold_req", mem_req, 0);
    check("idle_hold_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the core datapath.
- Fetches a 9-bit instruction, drives the ALU opcode, and holds the CMP flags in a flag register.
- Resolves branches, sequences load/store through a req/ack memory handshake, and steps the PC.
- Sits between instruction memory, register file, ALU and data memory; the top level launches it with start and sees done on halt.

Parameters:
- PC_W, 8, program counter width in bits.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before the fault halt.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves IDLE or HALTED.
- done  out  1  high while in HALTED.
- fault  out  1  high in HALTED if the halt was caused by a memory timeout.
- pc  out  PC_W  current instruction address.
- instr  in  9  instruction from instruction memory at pc (combinational read).
- alu_op  out  5  opcode to the ALU, equal to instr[8:4] in EXEC, else kMOV.
- alu_rslt  in  8  ALU result.
- alu_lt, alu_z  in  1  ALU compare outputs.
- rf_we  out  1  register file write enable (one cycle, in WB).
- rf_wsel  out  1  write data select: 0 = ALU result, 1 = memory read data.
- mem_req  out  1  data memory request, held until ack.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_ack  in  1  data memory completion.
- flag_lt, flag_z  out  1  latched flag register.

Behaviour:
- Reset values:
  - state = IDLE; pc = 0; flags = 0; fault = 0.
  - All outputs low, except alu_op = kMOV.
- States and transitions:
  - IDLE: on start, go to FETCH.
  - FETCH: one cycle for the instruction to settle; go to EXEC.
  - EXEC: alu_op = instr[8:4]. Decode by opcode:
    - kADD, kSUB, kAND, kXOR, kSLL, kSRL, kMOV: go to WB with rf_wsel = 0.
    - kCMP: flag_lt <= alu_lt and flag_z <= alu_z; pc += 1; go to FETCH. No write-back.
    - kBE/kBL/kBG/kBA: resolve the branch (conditions below); go to FETCH.
    - kLD: go to MEM_WAIT with mem_we = 0.
    - kST: go to MEM_WAIT with mem_we = 1.
    - kHALT: go to HALTED; pc is unchanged.
    - Any other opcode: treated as a NOP; pc += 1.
  - MEM_WAIT: mem_req held high and mem_we stable.
    - On mem_ack, drop mem_req. A load goes to WB with rf_wsel = 1; a store does pc += 1 and goes to FETCH.
    - If MEM_TIMEOUT cycles pass without ack: fault <= 1; go to HALTED.
  - WB: rf_we = 1 for exactly one cycle; pc += 1; go to FETCH.
  - HALTED: done = 1. On start, clear pc, flags and fault, then go to FETCH.
- Branch conditions, using the latched flags only (never the live ALU outputs):
  - kBE: taken if flag_z.
  - kBL: taken if flag_lt.
  - kBG: taken if !flag_z && !flag_lt.
  - kBA: always taken.
  - Taken: pc <= alu_rslt[PC_W-1:0], with the ALU passing the target as in_b. Not taken: pc += 1.
- PC arithmetic is modulo 2^PC_W; pc wraps from all-ones to 0 silently.
- Latency in cycles:
  - ALU instructions: 3 (FETCH, EXEC, WB).
  - CMP and branches: 2.
  - Stores: 2 + wait cycles.
  - Loads: 3 + wait cycles.
- An ack arriving in the same cycle the timeout expires counts as success. An ack outside MEM_WAIT is ignored.
- start outside IDLE or HALTED is ignored.
- reset mid-operation, including during MEM_WAIT, aborts immediately: mem_req drops asynchronously and the block returns to IDLE.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt (16 bits) and ret_cnt (16 bits).
  - cyc_cnt increments every cycle outside IDLE and HALTED.
  - ret_cnt increments once per retired instruction: on WB, on a CMP or branch EXEC, and on store completion.
  - Both counters saturate at 0xFFFF and clear on reset and on start.
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Package definitions (existing), extended with:
  - kHALT = 5'h1F;
  - ctrl_state_t enum {IDLE, FETCH, EXEC, MEM_WAIT, WB, HALTED};
  - the existing kXXX opcode constants.
- One sub-module, branch_resolve: combinational; inputs op, flag_lt, flag_z; output taken.

Test Plan:
- Reset, then start with program ADD, HALT → rf_we pulses in cycle 3 after FETCH; done after 5 cycles; pc = 1.
- CMP with alu_z = 1, then BE with alu_rslt = 0x20 → flag_z = 1; pc = 0x20. Repeat with alu_z = 0 → pc = 2.
- CMP with alu_lt = 0 and alu_z = 0, then BG → taken. Next a BL → not taken.
- LD with ack after 4 cycles → mem_req high for exactly 4 cycles, mem_we = 0, then rf_wsel = 1 with rf_we.
- ST with no ack → after 15 cycles fault = 1 and done = 1. A start pulse then clears fault and sets pc = 0.
- pc = 0xFF executing ADD → pc wraps to 0x00. Assert reset during MEM_WAIT → mem_req drops the same cycle and state = IDLE.
